// File: rtl/snn_pkg.sv
// Shared types and default sizing for the SNN inference controller slice.
package snn_pkg;

  localparam int unsigned DEF_NUM_CLASSES = 10;
  localparam int unsigned DEF_WIDTH       = 8;
  localparam int unsigned DEF_TIMESTEPS   = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_RUN,
    ST_SETTLE,
    ST_SCAN,
    ST_DONE
  } state_e;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/snn_argmax_scan.sv
// Sequential argmax: one accumulator per step, strict compare so ties keep the lowest index.
module snn_argmax_scan #(
  parameter int unsigned NUM_CLASSES = 10,
  parameter int unsigned WIDTH_P     = 8,
  parameter int unsigned IDX_W       = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           init,
  input  logic                           step,
  input  logic [NUM_CLASSES*WIDTH_P-1:0] acc,
  output logic [IDX_W-1:0]               next_idx,
  output logic [WIDTH_P-1:0]             next_score
);

  logic [IDX_W-1:0]   idx_q;
  logic [IDX_W-1:0]   best_idx_q;
  logic [WIDTH_P-1:0] best_score_q;
  logic [WIDTH_P-1:0] cur;
  logic               better;

  // The post-step best is exposed so the final compare can be captured on the same edge.
  always_comb begin
    cur        = acc[int'(idx_q) * int'(WIDTH_P) +: WIDTH_P];
    better     = step && (cur > best_score_q);
    next_score = better ? cur   : best_score_q;
    next_idx   = better ? idx_q : best_idx_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
    end else if (init) begin
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_score_q <= '0;
    end else if (step) begin
      best_idx_q   <= next_idx;
      best_score_q <= next_score;
      idx_q        <= (idx_q == IDX_W'(NUM_CLASSES - 1)) ? '0 : idx_q + 1'b1;
    end
  end

endmodule

// File: rtl/snn_inference_ctrl.sv
// Inference sequencer: clear, run timesteps, settle, argmax scan, publish result.
// Define SNN_CTRL_AUTO_RESTART_EN for continuous back-to-back inference.
module snn_inference_ctrl
  import snn_pkg::*;
#(
  parameter int unsigned NUM_CLASSES   = DEF_NUM_CLASSES,
  parameter int unsigned WIDTH_P       = DEF_WIDTH,
  parameter int unsigned TIMESTEPS     = DEF_TIMESTEPS,
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           start_i,
  input  logic                           abort_i,
  input  logic [NUM_CLASSES*WIDTH_P-1:0] acc_i,
  output logic                           clear_o,
  output logic                           sample_en_o,
  output logic                           busy_o,
  output logic                           result_valid_o,
  output logic [$clog2(NUM_CLASSES)-1:0] class_o,
  output logic [WIDTH_P-1:0]             score_o
);

  localparam int unsigned CLS_W   = $clog2(NUM_CLASSES);
  localparam int unsigned CNT_MAX = max3(TIMESTEPS, SETTLE_CYCLES, NUM_CLASSES);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CLS_W-1:0]   scan_idx;
  logic [WIDTH_P-1:0] scan_score;
  logic               scan_step;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_i && !abort_i) state_d = ST_CLEAR;
      ST_CLEAR:  state_d = abort_i ? ST_IDLE : ST_RUN;
      ST_RUN: begin
        if (abort_i) state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(TIMESTEPS - 1)) state_d = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (abort_i) state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) state_d = ST_SCAN;
      end
      ST_SCAN: begin
        if (abort_i) state_d = ST_IDLE;
        else if (cnt_q == CNT_W'(NUM_CLASSES - 1)) state_d = ST_DONE;
      end
      ST_DONE: begin
`ifdef SNN_CTRL_AUTO_RESTART_EN
        state_d = abort_i ? ST_IDLE : ST_CLEAR;
`else
        state_d = ST_IDLE;
`endif
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_d != state_q) ? '0 : cnt_q + 1'b1;
    end
  end

  // Result is captured on the edge entering DONE, so it is valid alongside the pulse.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      class_o <= '0;
      score_o <= '0;
    end else if (state_q == ST_SCAN && state_d == ST_DONE) begin
      class_o <= scan_idx;
      score_o <= scan_score;
    end
  end

  assign scan_step      = (state_q == ST_SCAN);
  assign clear_o        = (state_q == ST_CLEAR);
  assign sample_en_o    = (state_q == ST_RUN);
  assign busy_o         = (state_q != ST_IDLE);
  assign result_valid_o = (state_q == ST_DONE);

  snn_argmax_scan #(
    .NUM_CLASSES (NUM_CLASSES),
    .WIDTH_P     (WIDTH_P),
    .IDX_W       (CLS_W)
  ) u_scan (
    .clk        (clk_i),
    .rst_n      (rst_ni),
    .init       (!scan_step),
    .step       (scan_step),
    .acc        (acc_i),
    .next_idx   (scan_idx),
    .next_score (scan_score)
  );

endmodule

// File: tb/tb_snn_inference_ctrl.sv
// Randomized self-checking bench against a cycle-count/argmax reference model.
module tb_snn_inference_ctrl;

  localparam int NC  = 10;
  localparam int W   = 8;
  localparam int T   = 16;
  localparam int S   = 2;
  localparam int CW  = $clog2(NC);
  localparam int LAT = 1 + T + S + NC;

  logic          clk = 1'b0;
  logic          rst_ni, start_i, abort_i;
  logic [NC*W-1:0] acc_i;
  logic          clear_o, sample_en_o, busy_o, result_valid_o;
  logic [CW-1:0] class_o;
  logic [W-1:0]  score_o;

  int total = 0;
  int bad   = 0;
  int prev_class = 0;
  int prev_score = 0;

  always #5 clk = ~clk;

  snn_inference_ctrl #(
    .NUM_CLASSES   (NC),
    .WIDTH_P       (W),
    .TIMESTEPS     (T),
    .SETTLE_CYCLES (S)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .abort_i        (abort_i),
    .acc_i          (acc_i),
    .clear_o        (clear_o),
    .sample_en_o    (sample_en_o),
    .busy_o         (busy_o),
    .result_valid_o (result_valid_o),
    .class_o        (class_o),
    .score_o        (score_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: find the maximum value, then the lowest class holding it.
  function automatic void ref_argmax(input logic [NC*W-1:0] a, output int cls, output int sc);
    int v[NC];
    bit found;
    sc = 0;
    for (int i = 0; i < NC; i++) begin
      v[i] = int'(a[i*W +: W]);
      if (v[i] > sc) sc = v[i];
    end
    cls = 0;
    found = 0;
    for (int i = 0; i < NC; i++)
      if (!found && v[i] == sc) begin
        cls = i;
        found = 1;
      end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one inference; k counts edges after the accepting edge (k=0 is the CLEAR cycle).
  task automatic run_check(input logic [NC*W-1:0] a, input int extra_start_k);
    int cls, sc;
    ref_argmax(a, cls, sc);
    acc_i   = a;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k <= LAT + 1; k++) begin
      check($sformatf("clear@%0d", k),  clear_o,        k == 0);
      check($sformatf("sample@%0d", k), sample_en_o,    k >= 1 && k <= T);
      check($sformatf("valid@%0d", k),  result_valid_o, k == LAT);
      check($sformatf("busy@%0d", k),   busy_o,         k <= LAT);
      if (k == LAT) begin
        prev_class = cls;
        prev_score = sc;
      end
      check($sformatf("class@%0d", k), 32'(class_o), prev_class);
      check($sformatf("score@%0d", k), 32'(score_o), prev_score);
      start_i = (k == extra_start_k);
      if (k <= LAT) tick();
    end
    start_i = 1'b0;
  endtask

  function automatic logic [NC*W-1:0] rand_acc();
    logic [NC*W-1:0] a;
    bit narrow;
    narrow = $urandom_range(0, 1) == 1;
    for (int i = 0; i < NC; i++)
      a[i*W +: W] = narrow ? 8'($urandom_range(250, 255)) : 8'($urandom_range(0, 255));
    return a;
  endfunction

  initial begin
    logic [NC*W-1:0] a;
    rst_ni  = 1'b1;
    start_i = 1'b0;
    abort_i = 1'b0;
    acc_i   = '0;
    #3 rst_ni = 1'b0;
    #1;
    check("rst_busy", busy_o, 0);
    check("rst_clear", clear_o, 0);
    check("rst_sample", sample_en_o, 0);
    check("rst_valid", result_valid_o, 0);
    check("rst_class", 32'(class_o), 0);
    check("rst_score", 32'(score_o), 0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();

    // acc = {5,9,3,9,0,...}: tie at 9 resolves to class 1
    a = '0;
    a[0*W +: W] = 8'd5;
    a[1*W +: W] = 8'd9;
    a[2*W +: W] = 8'd3;
    a[3*W +: W] = 8'd9;
    run_check(a, -1);
    check("dir_class", 32'(class_o), 1);
    check("dir_score", 32'(score_o), 9);

    run_check('0, -1);

    a = '0;
    for (int i = 0; i < NC; i++) a[i*W +: W] = 8'd254;
    a[9*W +: W] = 8'd255;
    run_check(a, -1);
    check("top_class", 32'(class_o), 9);

    for (int n = 0; n < 10; n++) begin
      a = rand_acc();
      run_check(a, ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LAT)) : -1);
    end

    // start held high: one pulse, back to IDLE, then a fresh CLEAR
    a = rand_acc();
    acc_i = a;
    start_i = 1'b1;
    tick();
    for (int k = 0; k <= LAT + 2; k++) begin
      check($sformatf("hold_valid@%0d", k), result_valid_o, k == LAT);
      check($sformatf("hold_busy@%0d", k), busy_o, k != LAT + 1);
      check($sformatf("hold_clear@%0d", k), clear_o, k == 0 || k == LAT + 2);
      if (k < LAT + 2) tick();
    end
    ref_argmax(a, prev_class, prev_score);
    start_i = 1'b0;
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("hold_abort_busy", busy_o, 0);

    // start and abort together in IDLE
    start_i = 1'b1;
    abort_i = 1'b1;
    tick();
    start_i = 1'b0;
    abort_i = 1'b0;
    check("both_busy", busy_o, 0);
    check("both_clear", clear_o, 0);

    // abort during RUN cycle 5
    acc_i = rand_acc();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    check("ab_sample_k5", sample_en_o, 1);
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    check("ab_busy", busy_o, 0);
    check("ab_sample", sample_en_o, 0);
    check("ab_clear", clear_o, 0);
    for (int k = 0; k < LAT; k++) begin
      check($sformatf("ab_valid@%0d", k), result_valid_o, 0);
      tick();
    end
    check("ab_class", 32'(class_o), prev_class);
    check("ab_score", 32'(score_o), prev_score);

    // reset asserted during SCAN
    acc_i = rand_acc();
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int k = 0; k < 22; k++) tick();
    check("scan_busy", busy_o, 1);
    #2 rst_ni = 1'b0;
    #1;
    check("mid_rst_busy", busy_o, 0);
    check("mid_rst_valid", result_valid_o, 0);
    check("mid_rst_sample", sample_en_o, 0);
    check("mid_rst_clear", clear_o, 0);
    check("mid_rst_class", 32'(class_o), 0);
    check("mid_rst_score", 32'(score_o), 0);
    prev_class = 0;
    prev_score = 0;
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    run_check(rand_acc(), -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/snn_inference_ctrl.md
SNN_INFERENCE_CTRL -- requirements
Module: snn_inference_ctrl

Interface
REQ-001 SHALL have parameter NUM_CLASSES, default 10: number of readout accumulators scanned.
REQ-002 SHALL have parameter WIDTH_P, default 8: accumulator and score width.
REQ-003 SHALL have parameter TIMESTEPS, default 16: number of sample-enable cycles per inference.
REQ-004 SHALL have parameter SETTLE_CYCLES, default 2, minimum 1: drain cycles after the last timestep.
REQ-005 SHALL have port clk_i, input, 1: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_ni, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port start_i, input, 1: request one inference; sampled only in IDLE.
REQ-008 SHALL have port abort_i, input, 1: cancel the inference in progress.
REQ-009 SHALL have port acc_i, input, NUM_CLASSES*WIDTH_P: flattened accumulator outputs; class k occupies bits [k*WIDTH_P +: WIDTH_P].
REQ-010 SHALL have port clear_o, output, 1: synchronous clear strobe to the neuron and accumulator state.
REQ-011 SHALL have port sample_en_o, output, 1: advances the datapath by one timestep.
REQ-012 SHALL have port busy_o, output, 1: high in every state except IDLE.
REQ-013 SHALL have port result_valid_o, output, 1: one-cycle pulse when a new result is available.
REQ-014 SHALL have port class_o, output, $clog2(NUM_CLASSES): winning class index.
REQ-015 SHALL have port score_o, output, WIDTH_P: winning accumulator value.

Function
REQ-016 SHALL implement the states IDLE, CLEAR, RUN, SETTLE, SCAN and DONE.
REQ-017 SHALL transition IDLE->CLEAR on start_i=1; CLEAR lasts 1 cycle with clear_o=1.
REQ-018 SHALL stay in RUN for exactly TIMESTEPS cycles with sample_en_o=1, then enter SETTLE.
REQ-019 SHALL stay in SETTLE for exactly SETTLE_CYCLES cycles with sample_en_o=0, then enter SCAN.
REQ-020 SHALL stay in SCAN for exactly NUM_CLASSES cycles, comparing one accumulator per cycle for index 0..NUM_CLASSES-1.
REQ-021 SHALL load the running best (score 0, index 0) on SCAN entry and update it only when acc_i[idx] > best; strict compare, so ties go to the lowest index and all-zero accumulators give class 0, score 0.
REQ-022 SHALL in DONE register the best into class_o/score_o, pulse result_valid_o for 1 cycle, and return to IDLE.
REQ-023 SHALL hold class_o/score_o stable between DONE pulses, including across aborts.
REQ-024 SHALL assert result_valid_o on the edge 1+TIMESTEPS+SETTLE_CYCLES+NUM_CLASSES cycles after the accepting edge (29 at defaults).
REQ-025 SHALL ignore start_i in every state other than IDLE, with no queuing.
REQ-026 SHALL on abort_i=1 in any non-IDLE state go to IDLE on the next edge, with no result_valid_o pulse and sample_en_o/clear_o low from that edge on.
REQ-027 SHALL give abort_i priority over start_i; start_i and abort_i together in IDLE leave the block in IDLE.
REQ-028 SHALL never assert clear_o and sample_en_o in the same cycle.

Reset
REQ-029 SHALL on rst_ni=0 immediately force state IDLE, all counters 0, clear_o=0, sample_en_o=0, busy_o=0, result_valid_o=0, class_o=0 and score_o=0.
REQ-030 SHALL abandon any inference when reset is applied mid-operation; the first start_i after reset release starts a full sequence.

Configuration
REQ-031 SHALL, when SNN_CTRL_AUTO_RESTART_EN is defined, go DONE->CLEAR (continuous back-to-back inference) unless abort_i=1; abort_i returns it to IDLE.
REQ-032 SHALL, when SNN_CTRL_AUTO_RESTART_EN is undefined, go DONE->IDLE and start each inference only on start_i.

Structure
REQ-033 SHALL take the state enumeration and the default constants NUM_CLASSES, WIDTH_P and TIMESTEPS from the shared package snn_pkg.
REQ-034 SHALL implement the sequential argmax (running best, index counter, strict compare) as the sub-module snn_argmax_scan; the FSM and timers stay in the top.

Verification
REQ-035 SHALL cover this scenario: defaults, acc={5,9,3,9,0,...}, start_i pulse -> clear_o 1 cycle, sample_en_o 16 cycles, result_valid_o at edge +29, class_o=1, score_o=9.
REQ-036 SHALL cover this scenario: all acc=0 -> class_o=0, score_o=0, result_valid_o still pulses.
REQ-037 SHALL cover this scenario: acc[9]=255, others 254 -> class_o=9, score_o=255.
REQ-038 SHALL cover this scenario: start_i held high through a run -> exactly one result pulse, then a new run begins from IDLE (macro off).
REQ-039 SHALL cover this scenario: abort_i at RUN cycle 5 -> IDLE next edge, no result_valid_o, previous class_o/score_o unchanged.
REQ-040 SHALL cover this scenario: rst_ni low during SCAN -> all outputs 0 asynchronously; a start_i after release yields a normal 29-cycle result.
